// File: rtl/ex_alu_muldiv_if.sv
// rtl/ex_alu_muldiv_if.sv - request/response bundle for ex_alu_muldiv
// Request:  in_valid, in_ready, source_1, source_2, operation
// Response: out_valid, alu_result, hi_result, zero, div_by_zero, overflow
// master = operand/stall controller side, slave = ALU side.
interface ex_alu_muldiv_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] source_1;
    logic [WIDTH-1:0] source_2;
    logic [OP_W-1:0]  operation;
    logic             out_valid;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] hi_result;
    logic             zero;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output in_valid, source_1, source_2, operation,
        input  in_ready, out_valid, alu_result, hi_result, zero, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, source_1, source_2, operation,
        output in_ready, out_valid, alu_result, hi_result, zero, div_by_zero, overflow
    );
endinterface

// File: rtl/ex_alu_muldiv.sv
// rtl/ex_alu_muldiv.sv - execute-stage ALU with iterative multu/divu
// Ports: clk, rst (synchronous, active-high), bus (ex_alu_muldiv_if.slave).
// Single-cycle ops (and/or/add/sub/slt, unknown opcodes as add) complete one
// cycle after accept; multu/divu take WIDTH+1 cycles; divu by zero takes 1.
// Optional macro EX_ALU_OVF_EN enables signed overflow detection on add/sub.
module ex_alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    ex_alu_muldiv_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4'b0110);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(4'b0111);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(4'b1000);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(4'b1001);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opnd_q;       // multiplicand (multu) or divisor (divu)
    logic [WIDTH-1:0] hi_q, lo_q;   // partial product / remainder : multiplier / quotient
    logic [WIDTH-1:0] alu_result, hi_result;
    logic             zero, div_by_zero, overflow;

    logic [WIDTH-1:0] src_a, src_b;
    logic [OP_W-1:0]  op;
    logic             accept, last;
    logic [WIDTH-1:0] sum, diff, single_res;
    logic             single_ovf;
    logic             add_ovf, sub_ovf;

    assign src_a  = bus.source_1;
    assign src_b  = bus.source_2;
    assign op     = bus.operation;
    assign accept = bus.in_valid && (state == IDLE);
    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign sum    = src_a + src_b;
    assign diff   = src_a - src_b;

`ifdef EX_ALU_OVF_EN
    assign add_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
    assign sub_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
`else
    assign add_ovf = 1'b0;
    assign sub_ovf = 1'b0;
`endif

    always_comb begin
        single_res = sum;
        single_ovf = add_ovf;
        case (op)
            OP_AND:  begin single_res = src_a & src_b; single_ovf = 1'b0; end
            OP_OR:   begin single_res = src_a | src_b; single_ovf = 1'b0; end
            OP_SUB:  begin single_res = diff;          single_ovf = sub_ovf; end
            OP_SLT:  begin single_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)}; single_ovf = 1'b0; end
            default: begin single_res = sum;           single_ovf = add_ovf; end
        endcase
    end

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole product right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
    assign mul_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring-divide step: shift the next dividend bit into the remainder
    // and keep the subtraction only when it does not borrow.
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_next, div_lo_next;
    assign div_shift   = {hi_q, lo_q[WIDTH-1]};
    assign div_diff    = div_shift - {1'b0, opnd_q};
    assign div_ge      = ~div_diff[WIDTH];
    assign div_hi_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_next = {lo_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) begin
                if (op == OP_MULTU)                          state_next = MUL;
                else if (op == OP_DIVU && src_b != '0)       state_next = DIV;
                else                                         state_next = DONE;
            end
            MUL:  if (last) state_next = DONE;
            DIV:  if (last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            opnd_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            alu_result  <= '0;
            hi_result   <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (accept) begin
                    cnt  <= '0;
                    hi_q <= '0;
                    if (op == OP_MULTU) begin
                        opnd_q <= src_a;
                        lo_q   <= src_b;
                    end else if (op == OP_DIVU) begin
                        opnd_q <= src_b;
                        lo_q   <= src_a;
                        if (src_b == '0) begin
                            alu_result  <= '1;
                            hi_result   <= src_a;
                            zero        <= 1'b0;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end
                    end else begin
                        alu_result  <= single_res;
                        hi_result   <= '0;
                        zero        <= (single_res == '0);
                        div_by_zero <= 1'b0;
                        overflow    <= single_ovf;
                    end
                end
                MUL: begin
                    hi_q <= mul_hi_next;
                    lo_q <= mul_lo_next;
                    if (!last) cnt <= cnt + 1'b1;
                    else begin
                        alu_result  <= mul_lo_next;
                        hi_result   <= mul_hi_next;
                        zero        <= (mul_lo_next == '0);
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                DIV: begin
                    hi_q <= div_hi_next;
                    lo_q <= div_lo_next;
                    if (!last) cnt <= cnt + 1'b1;
                    else begin
                        alu_result  <= div_lo_next;
                        hi_result   <= div_hi_next;
                        zero        <= (div_lo_next == '0);
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.alu_result  = alu_result;
    assign bus.hi_result   = hi_result;
    assign bus.zero        = zero;
    assign bus.div_by_zero = div_by_zero;
    assign bus.overflow    = overflow;
endmodule
